// File: rtl/maxnet_loader.sv
// Streams four operands into a Maxnet, pulses its reset and start, then waits for done
// (or a timeout) and presents the winner downstream with a valid/ready handshake.
module maxnet_loader #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] X2,
  output logic [WIDTH-1:0] X3,
  output logic [WIDTH-1:0] X4,
  output logic             mx_rst,
  output logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             out_ready
);

  // Counter only needs to reach TIMEOUT-1; the last WAIT cycle is decided by compare.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLR,
    S_FIRE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t           state_reg;
  logic [1:0]       count_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic [WIDTH-1:0] x_reg [4];
  logic [WIDTH-1:0] out_data_reg;
  logic             out_err_reg;
  logic             accept;

  assign accept = (state_reg == S_LOAD) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_LOAD;
      count_reg    <= 2'd0;
      wait_cnt_reg <= '0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (in_valid) begin
            count_reg <= count_reg + 2'd1;
            if (count_reg == 2'd3) begin
              state_reg <= S_CLR;
            end
          end
        end
        S_CLR: begin
          state_reg <= S_FIRE;
        end
        S_FIRE: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over a timeout landing on the same cycle
          if (done) begin
            out_data_reg <= result;
            out_err_reg  <= 1'b0;
            state_reg    <= S_OUT;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            out_data_reg <= '0;
            out_err_reg  <= 1'b1;
            state_reg    <= S_OUT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_reg <= S_LOAD;
          end
        end
        default: begin
          state_reg <= S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        x_reg[i] <= '0;
      end else if (accept && (count_reg == 2'(i))) begin
        x_reg[i] <= in_data;
      end
    end
  end

  assign in_ready  = (state_reg == S_LOAD);
  assign mx_rst    = (state_reg == S_CLR);
  assign start     = (state_reg == S_FIRE);
  assign out_valid = (state_reg == S_OUT);
  assign out_data  = out_data_reg;
  assign out_err   = out_err_reg;
  assign X1        = x_reg[0];
  assign X2        = x_reg[1];
  assign X3        = x_reg[2];
  assign X4        = x_reg[3];

endmodule

// File: doc/maxnet_loader.md
MAXNET_LOADER -- requirements
Module: maxnet_loader

Interface
REQ-001 Parameter WIDTH, default 5, bit width of every data word (X1..X4, result, stream data).
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles allowed for Maxnet done before an error is flagged.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset on these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  loader accepts word this cycle.
- X1, X2, X3, X4  out  WIDTH each  operands to Maxnet.
- mx_rst  out  1  reset pulse to Maxnet.
- start  out  1  start pulse to Maxnet.
- done  in  1  Maxnet completion.
- result  in  WIDTH  Maxnet winner value, valid when done=1.
- out_valid  out  1  result word available downstream.
- out_data  out  WIDTH  captured result.
- out_err  out  1  qualifies out_data: 1 = timeout, no result.
- out_ready  in  1  downstream accepts result.

Function
REQ-004 The block SHALL implement the FSM LOAD -> CLR -> FIRE -> WAIT -> OUT -> LOAD; no other transitions except reset.
REQ-005 In LOAD: in_ready=1; a word is accepted on a rising edge with in_valid&&in_ready; the k-th accepted word (k=0..3) SHALL be written to X(k+1); a 2-bit count increments per accept.
REQ-006 On the 4th accept, the FSM SHALL enter CLR on the next edge and clear count to 0.
REQ-007 In CLR: mx_rst=1 for exactly one cycle, then FIRE.
REQ-008 In FIRE: start=1 for exactly one cycle, then WAIT; mx_rst and start SHALL be 0 in every other state.
REQ-009 In WAIT: a cycle counter starts at 0 on entry and increments each cycle; done=1 SHALL capture result into out_data, clear out_err, and move to OUT on that edge.
REQ-010 If done is not seen within TIMEOUT WAIT cycles, the FSM SHALL set out_data=0, out_err=1, and move to OUT; done and the timeout on the same cycle SHALL be treated as done.
REQ-011 In OUT: out_valid=1; out_data and out_err SHALL stay stable until out_valid&&out_ready, after which the FSM returns to LOAD on the next edge.
REQ-012 in_ready SHALL be 0 in every state but LOAD; in_valid outside LOAD SHALL be ignored and no X register changes.
REQ-013 done outside WAIT SHALL be ignored.
REQ-014 X1..X4 SHALL hold their values from the 4th accept through CLR, FIRE, WAIT and OUT, changing only on a LOAD accept.
REQ-015 Latency: 4th accept at edge N gives mx_rst high in cycle N+1, start high in cycle N+2, WAIT from N+3; done seen at edge M gives out_valid from cycle M+1.
REQ-016 Back-to-back: after the OUT handshake, in_ready SHALL be 1 in the very next cycle; no word is accepted while OUT is pending.
REQ-017 All outputs SHALL be registered or decoded only from the FSM state; no combinational path from in_valid, done or out_ready to any output.

Reset
REQ-018 On rst=1 at a clock edge the block SHALL enter LOAD with count=0 and X1..X4=0, mx_rst=0, start=0, out_valid=0, out_data=0, out_err=0, and in_ready=1 from the following cycle.
REQ-019 Reset in any state (mid-load, FIRE, WAIT, OUT) SHALL abandon the operation and discard any partial operands and pending result.

Verification
REQ-020 Stream 1,2,3,4 with a real Maxnet -> X1..X4=1,2,3,4; one-cycle mx_rst then one-cycle start; out_data=4, out_err=0.
REQ-021 Streams 7,2,1,4 / 3,6,7,4 / 7,5,5,4, each after the previous OUT handshake -> out_data=7 each time, out_err=0, in_ready back to 1 the cycle after each handshake.
REQ-022 in_valid toggling with gaps between words, out_ready held low 10 cycles -> words land in order; out_valid and out_data stable 10 cycles; in_ready=0 throughout.
REQ-023 Stubbed done never asserted, TIMEOUT=8 -> out_valid rises exactly 9 cycles after start is high, with out_data=0 and out_err=1.
REQ-024 rst asserted after 2 accepted words, and again during WAIT -> all outputs zero next cycle; the next 4 words fill X1..X4 from X1.
REQ-025 done pulsed during LOAD and OUT -> no state change; in_valid pulsed during WAIT -> X registers unchanged.
